dds_sweep_scheduler: RTL and testbench
======================================

DDS_SWEEP_SCHEDULER -- requirements
Module: dds_sweep_scheduler

Interface
REQ-001 SHALL have parameter PHASE_BITS, default 32, width of each channel's phase increment.
REQ-002 SHALL have parameter STEP_COUNT_BITS, default 16, width of the sweep step count.
REQ-003 SHALL have parameter DWELL_BITS, default 16, width of the dwell count in clk cycles.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is in this domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg  Axis_If.Slave  tx_pkg::CHANNELS*2*PHASE_BITS+STEP_COUNT_BITS+DWELL_BITS+1  sweep configuration.
REQ-007 SHALL have port trigger  input  1  starts a sweep.
REQ-008 SHALL have port abort  input  1  stops a sweep.
REQ-009 SHALL have port phase_inc  Axis_If.Master  tx_pkg::CHANNELS*PHASE_BITS  phase-increment words, channel c at [c*PHASE_BITS+:PHASE_BITS]; feeds the DDS phase_inc input.
REQ-010 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at normal sweep completion.

Function
REQ-012 SHALL decode cfg.data, LSB first, as:
 - start[c] at c*PHASE_BITS;
 - step[c] (two's complement) at CHANNELS*PHASE_BITS + c*PHASE_BITS;
 - then num_steps (STEP_COUNT_BITS);
 - then dwell (DWELL_BITS);
 - then repeat (1 bit, MSB).
REQ-013 SHALL implement FSM states IDLE, EMIT, DWELL and DONE.
REQ-014 SHALL drive cfg.ready = 1 only in IDLE, and latch cfg.data on cfg.valid&&cfg.ready, setting internal flag cfg_loaded.
REQ-015 SHALL, in IDLE with trigger=1 and (cfg_loaded or a cfg handshake the same cycle), load cur[c]=start[c] and step_idx=0 from the newest config, then enter EMIT; phase_inc.valid is asserted the next cycle.
REQ-016 SHALL ignore trigger when no config has been loaded or when state != IDLE.
REQ-017 SHALL, in EMIT, assert phase_inc.valid with data=cur[] held stable until phase_inc.ready; on the handshake cycle it enters DWELL.
REQ-018 SHALL stay in DWELL for max(dwell,1) cycles, so handshake at cycle h gives next phase_inc.valid at h+max(dwell,1)+1.
REQ-019 SHALL, at DWELL expiry with step_idx<num_steps, set cur[c] <= cur[c]+step[c] modulo 2^PHASE_BITS, increment step_idx, and enter EMIT.
REQ-020 SHALL, at DWELL expiry with step_idx==num_steps:
 - if repeat=1, reload cur[c]=start[c], set step_idx=0, and enter EMIT;
 - otherwise enter DONE.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE; the config is retained, so a new trigger replays the sweep.
REQ-022 SHALL emit num_steps+1 words per pass; num_steps=0 emits start[] only.
REQ-023 SHALL act on abort=1 as follows:
 - in DWELL: enter IDLE next cycle;
 - in EMIT: enter IDLE after the pending handshake, without dropping valid early;
 - in DONE: has no effect;
 - in all cases no further words are emitted and no done pulse is issued for the aborted sweep.
REQ-024 SHALL give abort priority over repeat and step advance when both occur in the same cycle.

Reset
REQ-025 SHALL, on reset assertion, asynchronously force:
 - state=IDLE, cfg_loaded=0, cur[]=0, step_idx=0 and the dwell counter to 0;
 - phase_inc.valid=0, phase_inc.data=0, busy=0, done=0.
REQ-026 SHALL, on reset mid-sweep, discard the sweep and the config; after release cfg.ready=1 and trigger is ignored until a new config is accepted.

Structure
REQ-027 SHALL place typedef dds_sweep_cfg_t (packed struct of the REQ-012 fields) and the FSM state enum in tx_pkg.
REQ-028 SHALL be a single module with no sub-modules; the dwell counter and per-channel adders are inline.

Verification
REQ-029 SHALL cover: cfg ch0 start=0x1000_0000, step=0x0100_0000, num_steps=3, dwell=4, repeat=0, then trigger -> words 0x1000_0000, 0x1100_0000, 0x1200_0000, 0x1300_0000 spaced 5 cycles; done pulses once; busy falls.
REQ-030 SHALL cover: phase_inc.ready held low 10 cycles during EMIT -> data/valid stable; dwell starts only after the handshake.
REQ-031 SHALL cover: step=0xFFFF_FFFF (-1), start=0x0000_0001, num_steps=2 -> words 0x1, 0x0, 0xFFFF_FFFF (wrap).
REQ-032 SHALL cover: repeat=1, num_steps=1, then abort during second-pass DWELL -> words start, start+step, start, and no done pulse.
REQ-033 SHALL cover: trigger before any cfg is ignored; cfg and trigger in the same cycle start the sweep with the new cfg; dwell=0 behaves as dwell=1.
REQ-034 SHALL cover: reset asserted mid-EMIT -> valid drops asynchronously; a later trigger without a new cfg produces no output.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types for the DDS sweep scheduler: FSM state encoding and the
// default-width layout of the sweep configuration word.
package tx_pkg;

    localparam int CHANNELS            = 2;
    localparam int DEF_PHASE_BITS      = 32;
    localparam int DEF_STEP_COUNT_BITS = 16;
    localparam int DEF_DWELL_BITS      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Declared MSB first, so start[0] occupies bit 0 of the packed word.
    typedef struct packed {
        logic                                     rpt;
        logic [DEF_DWELL_BITS-1:0]                dwell;
        logic [DEF_STEP_COUNT_BITS-1:0]           num_steps;
        logic [CHANNELS-1:0][DEF_PHASE_BITS-1:0]  step;
        logic [CHANNELS-1:0][DEF_PHASE_BITS-1:0]  start;
    } dds_sweep_cfg_t;

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream interface used for the config and phase ports.
interface Axis_If #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/dds_sweep_scheduler.sv
// Steps per-channel DDS phase increments through a linear sweep, holding each
// word for a programmable dwell, with optional repeat and abort.
module dds_sweep_scheduler
    import tx_pkg::*;
#(
    parameter int PHASE_BITS      = 32,
    parameter int STEP_COUNT_BITS = 16,
    parameter int DWELL_BITS      = 16
) (
    input  logic   clk,
    input  logic   reset,
    Axis_If.Slave  cfg,
    input  logic   trigger,
    input  logic   abort,
    Axis_If.Master phase_inc,
    output logic   busy,
    output logic   done
);

    localparam int STEP_LSB  = CHANNELS * PHASE_BITS;
    localparam int NUM_LSB   = 2 * CHANNELS * PHASE_BITS;
    localparam int DWELL_LSB = NUM_LSB + STEP_COUNT_BITS;
    localparam int RPT_BIT   = DWELL_LSB + DWELL_BITS;

    sweep_state_t state, state_nxt;

    logic [PHASE_BITS-1:0]      start_r [CHANNELS];
    logic [PHASE_BITS-1:0]      step_r  [CHANNELS];
    logic [STEP_COUNT_BITS-1:0] num_steps_r;
    logic [DWELL_BITS-1:0]      dwell_r;
    logic                       rpt_r;

    logic                       cfg_loaded;
    logic [PHASE_BITS-1:0]      cur       [CHANNELS];
    logic [PHASE_BITS-1:0]      start_new [CHANNELS];
    logic [STEP_COUNT_BITS-1:0] step_idx;
    logic [DWELL_BITS-1:0]      dwell_cnt;
    logic                       abort_pend;

    logic cfg_hs, start_go, emit_hs, dwell_exp, last_step, abort_hit;

    assign cfg_hs    = (state == IDLE) && cfg.valid;
    assign start_go  = (state == IDLE) && trigger && (cfg_loaded || cfg_hs);
    assign emit_hs   = (state == EMIT) && phase_inc.ready;
    assign dwell_exp = (state == DWELL) && (dwell_cnt == '0);
    assign last_step = (step_idx == num_steps_r);
    assign abort_hit = abort || abort_pend;

    // A config arriving with the trigger must win over the stored one.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            start_new[c] = cfg_hs ? cfg.data[c*PHASE_BITS +: PHASE_BITS] : start_r[c];
        end
    end

    // NOTE: config storage has no reset; cfg_loaded alone decides whether it is valid.
    always_ff @(posedge clk) begin
        if (cfg_hs) begin
            for (int c = 0; c < CHANNELS; c++) begin
                start_r[c] <= cfg.data[c*PHASE_BITS +: PHASE_BITS];
                step_r[c]  <= cfg.data[STEP_LSB + c*PHASE_BITS +: PHASE_BITS];
            end
            num_steps_r <= cfg.data[NUM_LSB +: STEP_COUNT_BITS];
            dwell_r     <= cfg.data[DWELL_LSB +: DWELL_BITS];
            rpt_r       <= cfg.data[RPT_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_go) state_nxt = EMIT;
            end
            EMIT: begin
                if (emit_hs) state_nxt = abort_hit ? IDLE : DWELL;
            end
            DWELL: begin
                if (abort)
                    state_nxt = IDLE;
                else if (dwell_exp)
                    state_nxt = (!last_step || rpt_r) ? EMIT : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg.ready       = (state == IDLE);
        phase_inc.valid = (state == EMIT);
        busy            = (state != IDLE);
        done            = (state == DONE);
        phase_inc.data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            phase_inc.data[c*PHASE_BITS +: PHASE_BITS] = cur[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_loaded <= 1'b0;
            step_idx   <= '0;
            dwell_cnt  <= '0;
            abort_pend <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) cur[c] <= '0;
        end else begin
            if (cfg_hs) cfg_loaded <= 1'b1;

            // An abort seen while waiting for ready is remembered until the handshake.
            if (state == EMIT) begin
                if (emit_hs)    abort_pend <= 1'b0;
                else if (abort) abort_pend <= 1'b1;
            end else begin
                abort_pend <= 1'b0;
            end

            if (emit_hs) begin
                dwell_cnt <= (dwell_r == '0) ? '0 : dwell_r - DWELL_BITS'(1);
            end else if ((state == DWELL) && (dwell_cnt != '0)) begin
                dwell_cnt <= dwell_cnt - DWELL_BITS'(1);
            end

            if (start_go) begin
                step_idx <= '0;
                for (int c = 0; c < CHANNELS; c++) cur[c] <= start_new[c];
            end else if (dwell_exp && !abort) begin
                if (!last_step) begin
                    step_idx <= step_idx + STEP_COUNT_BITS'(1);
                    for (int c = 0; c < CHANNELS; c++) cur[c] <= cur[c] + step_r[c];
                end else if (rpt_r) begin
                    step_idx <= '0;
                    for (int c = 0; c < CHANNELS; c++) cur[c] <= start_r[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Directed bench for dds_sweep_scheduler: stimulus pushes expected words into
// a queue, a monitor pops and compares them on each phase_inc handshake.
module tb_dds_sweep_scheduler;
    import tx_pkg::*;

    localparam int PB    = 32;
    localparam int CFG_W = $bits(dds_sweep_cfg_t);
    localparam int PI_W  = CHANNELS * PB;

    typedef struct {
        logic [PI_W-1:0] data;
        int              gap;
    } exp_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic trigger = 1'b0;
    logic abort   = 1'b0;
    logic busy, done;

    Axis_If #(.DATA_W(CFG_W)) cfg_if ();
    Axis_If #(.DATA_W(PI_W))  pi_if ();

    dds_sweep_scheduler #(
        .PHASE_BITS(32), .STEP_COUNT_BITS(16), .DWELL_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .cfg(cfg_if), .trigger(trigger),
        .abort(abort), .phase_inc(pi_if), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_hs = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic dds_sweep_cfg_t mk_cfg(input logic [31:0] s0, input logic [31:0] d0,
                                              input logic [31:0] s1, input logic [31:0] d1,
                                              input logic [15:0] n, input logic [15:0] dw,
                                              input logic r);
        dds_sweep_cfg_t c;
        c.start[0]  = s0;
        c.start[1]  = s1;
        c.step[0]   = d0;
        c.step[1]   = d1;
        c.num_steps = n;
        c.dwell     = dw;
        c.rpt       = r;
        return c;
    endfunction

    function automatic void push_word(input logic [31:0] c0, input logic [31:0] c1, input int gap);
        exp_t it;
        it.data = {c1, c0};
        it.gap  = gap;
        exp_q.push_back(it);
    endfunction

    // Monitor: compares every accepted word against the scoreboard queue.
    always @(negedge clk) begin
        exp_t it;
        if (!reset) begin
            if (pi_if.valid && pi_if.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(pi_if.data), 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    check("word", 64'(pi_if.data), 64'(it.data));
                    if (it.gap > 0) check("word_gap", 64'(cyc - last_hs), 64'(it.gap));
                end
                last_hs = cyc;
            end
            if (done) done_cnt++;
        end
    end

    task automatic send_cfg(input dds_sweep_cfg_t c, input bit trig);
        @(posedge clk); #1;
        cfg_if.valid = 1'b1;
        cfg_if.data  = c;
        trigger      = trig;
        @(negedge clk);
        check("cfg_ready", 64'(cfg_if.ready), 64'd1);
        @(posedge clk); #1;
        cfg_if.valid = 1'b0;
        trigger      = 1'b0;
        if (trig) begin
            @(negedge clk);
            check("valid_after_cfg_trigger", 64'(pi_if.valid), 64'd1);
        end
    endtask

    task automatic fire(input bit expect_start);
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
        @(negedge clk);
        check("valid_after_trigger", 64'(pi_if.valid), 64'(expect_start));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_q_empty(input string name);
        int n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        dds_sweep_cfg_t c;
        int d;
        int n;

        cfg_if.valid = 1'b0;
        cfg_if.data  = '0;
        pi_if.ready  = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_valid", 64'(pi_if.valid), 64'd0);
        check("rst_data",  64'(pi_if.data),  64'd0);
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_done",  64'(done),        64'd0);
        check("rst_cfg_ready", 64'(cfg_if.ready), 64'd1);

        // Trigger with no config must be ignored.
        fire(0);
        check("no_cfg_busy", 64'(busy), 64'd0);

        // Basic four-word sweep, dwell 4 -> 5-cycle spacing, then replay.
        c = mk_cfg(32'h1000_0000, 32'h0100_0000, 32'h8000_0000, 32'h0000_0010, 16'd3, 16'd4, 1'b0);
        for (int p = 0; p < 2; p++) begin
            push_word(32'h1000_0000, 32'h8000_0000, 0);
            push_word(32'h1100_0000, 32'h8000_0010, 5);
            push_word(32'h1200_0000, 32'h8000_0020, 5);
            push_word(32'h1300_0000, 32'h8000_0030, 5);
            d = done_cnt;
            if (p == 0) send_cfg(c, 1'b0);
            fire(1);
            wait_idle("t1_idle");
            check("t1_q_empty", 64'(exp_q.size()), 64'd0);
            check("t1_done_pulses", 64'(done_cnt - d), 64'd1);
        end

        // Backpressure: word held stable, dwell counted from the handshake.
        pi_if.ready = 1'b0;
        push_word(32'h1000_0000, 32'h8000_0000, 0);
        push_word(32'h1100_0000, 32'h8000_0010, 5);
        push_word(32'h1200_0000, 32'h8000_0020, 5);
        push_word(32'h1300_0000, 32'h8000_0030, 5);
        d = done_cnt;
        fire(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(pi_if.valid), 64'd1);
            check("bp_data",  64'(pi_if.data),  64'h8000_0000_1000_0000);
        end
        @(posedge clk); #1 pi_if.ready = 1'b1;
        wait_idle("t2_idle");
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);
        check("t2_done_pulses", 64'(done_cnt - d), 64'd1);

        // Negative step wraps modulo 2^32.
        c = mk_cfg(32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 16'd2, 16'd2, 1'b0);
        push_word(32'h0000_0001, 32'hFFFF_FFFE, 0);
        push_word(32'h0000_0000, 32'hFFFF_FFFF, 3);
        push_word(32'hFFFF_FFFF, 32'h0000_0000, 3);
        d = done_cnt;
        send_cfg(c, 1'b0);
        fire(1);
        wait_idle("t3_idle");
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);
        check("t3_done_pulses", 64'(done_cnt - d), 64'd1);

        // Repeat mode, aborted during the second pass's dwell.
        c = mk_cfg(32'h0000_0100, 32'h0000_0020, 32'h0000_0000, 32'h0000_0005, 16'd1, 16'd3, 1'b1);
        push_word(32'h0000_0100, 32'h0000_0000, 0);
        push_word(32'h0000_0120, 32'h0000_0005, 4);
        push_word(32'h0000_0100, 32'h0000_0000, 4);
        d = done_cnt;
        send_cfg(c, 1'b0);
        fire(1);
        wait_q_empty("t4_words");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle("t4_idle");
        repeat (20) @(negedge clk);
        check("t4_busy_after", 64'(busy), 64'd0);
        check("t4_no_done", 64'(done_cnt - d), 64'd0);

        // Abort while EMIT is stalled: valid held until handshake, then idle.
        c = mk_cfg(32'h0000_0040, 32'h0000_0001, 32'h0000_0050, 32'h0000_0002, 16'd2, 16'd1, 1'b0);
        pi_if.ready = 1'b0;
        push_word(32'h0000_0040, 32'h0000_0050, 0);
        d = done_cnt;
        send_cfg(c, 1'b0);
        fire(1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("t4b_valid_held", 64'(pi_if.valid), 64'd1);
        @(posedge clk); #1 pi_if.ready = 1'b1;
        wait_idle("t4b_idle");
        repeat (10) @(negedge clk);
        check("t4b_q_empty", 64'(exp_q.size()), 64'd0);
        check("t4b_no_done", 64'(done_cnt - d), 64'd0);

        // Config and trigger together use the new config; dwell 0 acts as 1.
        c = mk_cfg(32'hA000_0000, 32'h0000_0001, 32'h0000_0005, 32'h0000_0010, 16'd2, 16'd0, 1'b0);
        push_word(32'hA000_0000, 32'h0000_0005, 0);
        push_word(32'hA000_0001, 32'h0000_0015, 2);
        push_word(32'hA000_0002, 32'h0000_0025, 2);
        d = done_cnt;
        send_cfg(c, 1'b1);
        wait_idle("t5_idle");
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
        check("t5_done_pulses", 64'(done_cnt - d), 64'd1);

        // Reset mid-EMIT drops valid at once and discards the config.
        c = mk_cfg(32'h0000_7000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 16'd3, 16'd2, 1'b0);
        pi_if.ready = 1'b0;
        send_cfg(c, 1'b0);
        fire(1);
        repeat (2) @(negedge clk);
        check("t6_valid_pre", 64'(pi_if.valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_valid", 64'(pi_if.valid), 64'd0);
        check("t6_async_data",  64'(pi_if.data),  64'd0);
        check("t6_async_busy",  64'(busy),        64'd0);
        @(posedge clk); #1 reset = 1'b0;
        pi_if.ready = 1'b1;
        @(negedge clk);
        check("t6_cfg_ready", 64'(cfg_if.ready), 64'd1);
        fire(0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (pi_if.valid) n++;
        end
        check("t6_no_output", 64'(n), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
